// File: rtl/fll_cfg_pkg.sv
// FLL configuration arbiter: shared types and constants.
package fll_cfg_pkg;

    localparam int FLL_ADDR_W      = 2;
    localparam int FLL_DATA_W      = 32;
    localparam int FLL_TIMEOUT_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        RESP
    } fll_state_e;

    typedef logic req_idx_t;

    typedef struct packed {
        logic                  wrn;
        logic [FLL_ADDR_W-1:0] add;
        logic [FLL_DATA_W-1:0] data;
    } fll_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: combinational grant, registered
// priority handed to the other requester when a transaction completes.
module rr_arb2
    import fll_cfg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       done_i,
    input  req_idx_t   done_idx_i,
    output logic       gnt_vld_o,
    output req_idx_t   gnt_idx_o
);

    req_idx_t prio_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else if (done_i) begin
            prio_q <= ~done_idx_i;
        end
    end

    // Contention resolves by priority; a sole requester always wins.
    assign gnt_vld_o = |req_i;
    assign gnt_idx_o = (&req_i) ? prio_q : req_i[1];

endmodule

// File: rtl/fll_cfg_arbiter.sv
// Arbitrates two requesters onto the FLL configuration port with an
// ack timeout; one committed transaction at a time.
module fll_cfg_arbiter
    import fll_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = FLL_TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic                  m0_wrn_i,
    input  logic [FLL_ADDR_W-1:0] m0_add_i,
    input  logic [FLL_DATA_W-1:0] m0_data_i,
    output logic                  m0_ack_o,
    output logic [FLL_DATA_W-1:0] m0_r_data_o,
    output logic                  m0_err_o,
    input  logic                  m1_req_i,
    input  logic                  m1_wrn_i,
    input  logic [FLL_ADDR_W-1:0] m1_add_i,
    input  logic [FLL_DATA_W-1:0] m1_data_i,
    output logic                  m1_ack_o,
    output logic [FLL_DATA_W-1:0] m1_r_data_o,
    output logic                  m1_err_o,
    output logic                  fll_req_o,
    output logic                  fll_wrn_o,
    output logic [FLL_ADDR_W-1:0] fll_add_o,
    output logic [FLL_DATA_W-1:0] fll_data_o,
    input  logic                  fll_ack_i,
    input  logic [FLL_DATA_W-1:0] fll_r_data_i,
    output logic                  busy_o
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);

    fll_state_e            state_q;
    fll_state_e            state_d;
    fll_cmd_t              cmd_q;
    fll_cmd_t              req_cmd;
    req_idx_t              gnt_q;
    req_idx_t              gnt_idx;
    logic                  gnt_vld;
    logic [CNT_W-1:0]      cnt_q;
    logic                  err_q;
    logic [FLL_DATA_W-1:0] r0_q;
    logic [FLL_DATA_W-1:0] r1_q;
    logic [FLL_DATA_W-1:0] rsp_data;
    logic                  timeout;
    logic                  wait_done;
    logic                  resp;

    rr_arb2 u_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      ({m1_req_i, m0_req_i}),
        .done_i     (resp),
        .done_idx_i (gnt_q),
        .gnt_vld_o  (gnt_vld),
        .gnt_idx_o  (gnt_idx)
    );

    always_comb begin
        req_cmd = '0;
        if (gnt_idx) begin
            req_cmd.wrn  = m1_wrn_i;
            req_cmd.add  = m1_add_i;
            req_cmd.data = m1_data_i;
        end else begin
            req_cmd.wrn  = m0_wrn_i;
            req_cmd.add  = m0_add_i;
            req_cmd.data = m0_data_i;
        end
    end

    assign timeout   = (cnt_q == CNT_LAST);
    assign wait_done = (state_q == WAIT_ACK)
                     && (fll_ack_i || timeout);
    // A late ack on the timeout cycle still wins; writes return zero.
    assign rsp_data  = (fll_ack_i && cmd_q.wrn)
                     ? fll_r_data_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (gnt_vld) state_d = ISSUE;
            ISSUE:    state_d = WAIT_ACK;
            WAIT_ACK: if (wait_done) state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_q <= '0;
            gnt_q <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
            r0_q  <= '0;
            r1_q  <= '0;
        end else begin
            if (state_q == IDLE && gnt_vld) begin
                cmd_q <= req_cmd;
                gnt_q <= gnt_idx;
            end
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT_ACK) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (wait_done) begin
                err_q <= ~fll_ack_i;
                if (gnt_q) begin
                    r1_q <= rsp_data;
                end else begin
                    r0_q <= rsp_data;
                end
            end
        end
    end

    assign resp        = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);
    assign fll_req_o   = (state_q == ISSUE)
                       || (state_q == WAIT_ACK);
    assign fll_wrn_o   = cmd_q.wrn;
    assign fll_add_o   = cmd_q.add;
    assign fll_data_o  = cmd_q.data;
    assign m0_ack_o    = resp & ~gnt_q;
    assign m1_ack_o    = resp & gnt_q;
    assign m0_err_o    = m0_ack_o & err_q;
    assign m1_err_o    = m1_ack_o & err_q;
    assign m0_r_data_o = r0_q;
    assign m1_r_data_o = r1_q;

endmodule

// File: tb/tb_fll_cfg_arbiter.sv
// Directed and randomised bench for fll_cfg_arbiter, checked against a
// transaction-level model of arbitration, ack latency and timeout.
module tb_fll_cfg_arbiter;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_wrn_i, m0_ack_o, m0_err_o;
    logic [1:0]  m0_add_i;
    logic [31:0] m0_data_i, m0_r_data_o;
    logic        m1_req_i, m1_wrn_i, m1_ack_o, m1_err_o;
    logic [1:0]  m1_add_i;
    logic [31:0] m1_data_i, m1_r_data_o;
    logic        fll_req_o, fll_wrn_o, fll_ack_i, busy_o;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_data_o, fll_r_data_i;

    int          n_assert = 0;
    int          n_fail = 0;
    int          prio;
    logic [31:0] mdl_rd [2];
    int          fll_lat;
    int          age;
    bit          fll_mute;
    bit          stray;
    logic [31:0] fll_rd;

    always #5 clk_i = ~clk_i;

    fll_cfg_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .m0_req_i     (m0_req_i),
        .m0_wrn_i     (m0_wrn_i),
        .m0_add_i     (m0_add_i),
        .m0_data_i    (m0_data_i),
        .m0_ack_o     (m0_ack_o),
        .m0_r_data_o  (m0_r_data_o),
        .m0_err_o     (m0_err_o),
        .m1_req_i     (m1_req_i),
        .m1_wrn_i     (m1_wrn_i),
        .m1_add_i     (m1_add_i),
        .m1_data_i    (m1_data_i),
        .m1_ack_o     (m1_ack_o),
        .m1_r_data_o  (m1_r_data_o),
        .m1_err_o     (m1_err_o),
        .fll_req_o    (fll_req_o),
        .fll_wrn_o    (fll_wrn_o),
        .fll_add_o    (fll_add_o),
        .fll_data_o   (fll_data_o),
        .fll_ack_i    (fll_ack_i),
        .fll_r_data_i (fll_r_data_i),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the FLL acks on the fll_lat-th cycle of its request.
    task automatic tick();
        @(posedge clk_i);
        #1;
        fll_ack_i = stray;
        fll_r_data_i = $urandom;
        if (fll_req_o) begin
            age++;
            if (!fll_mute && age == fll_lat) begin
                fll_ack_i = 1'b1;
                fll_r_data_i = fll_rd;
            end
        end else begin
            age = 0;
        end
    endtask

    task automatic run_txn(input int lat, input logic [31:0] frd,
                           input bit mute, input bit drop);
        int          w, n, exp_n;
        bit          ok;
        logic [34:0] exp_cmd;
        logic [31:0] exp_rd;
        w = (m0_req_i && m1_req_i) ? prio : (m1_req_i ? 1 : 0);
        exp_cmd = (w == 1) ? {m1_wrn_i, m1_add_i, m1_data_i}
                           : {m0_wrn_i, m0_add_i, m0_data_i};
        ok = !mute && lat >= 2 && lat <= TMO + 1;
        exp_n = ok ? lat + 1 : TMO + 2;
        exp_rd = (ok && exp_cmd[34]) ? frd : 32'h0;
        fll_lat = lat;
        fll_rd = frd;
        fll_mute = mute;
        tick();
        if (drop) begin
            if (w == 1) m1_req_i = 1'b0;
            else m0_req_i = 1'b0;
        end
        n = 1;
        while (!(m0_ack_o || m1_ack_o) && n < 3 * TMO) begin
            chk("fll_req", 64'(fll_req_o), 64'(1));
            chk("fll_cmd", 64'({fll_wrn_o, fll_add_o, fll_data_o}),
                64'(exp_cmd));
            chk("busy", 64'(busy_o), 64'(1));
            tick();
            n++;
        end
        chk("ack_cycle", 64'(n), 64'(exp_n));
        chk("ack_vec", 64'({m1_ack_o, m0_ack_o}),
            64'((w == 1) ? 2'b10 : 2'b01));
        chk("err_vec", 64'({m1_err_o, m0_err_o}),
            64'(ok ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01)));
        chk("fll_req_drop", 64'(fll_req_o), 64'(0));
        mdl_rd[w] = exp_rd;
        chk("r_data0", 64'(m0_r_data_o), 64'(mdl_rd[0]));
        chk("r_data1", 64'(m1_r_data_o), 64'(mdl_rd[1]));
        prio = 1 - w;
        tick();
        chk("ack_clear",
            64'({m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, busy_o}),
            64'(0));
        chk("r_hold0", 64'(m0_r_data_o), 64'(mdl_rd[0]));
        chk("r_hold1", 64'(m1_r_data_o), 64'(mdl_rd[1]));
    endtask

    initial begin
        rst_i = 1'b1;
        {m0_req_i, m0_wrn_i, m0_add_i, m0_data_i} = '0;
        {m1_req_i, m1_wrn_i, m1_add_i, m1_data_i} = '0;
        fll_ack_i = 1'b0;
        fll_r_data_i = '0;
        fll_lat = 0;
        fll_mute = 1'b0;
        stray = 1'b0;
        age = 0;
        prio = 0;
        mdl_rd[0] = '0;
        mdl_rd[1] = '0;
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_fll",
            64'({fll_req_o, fll_wrn_o, fll_add_o, fll_data_o}), 64'(0));
        chk("rst_m",
            64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, busy_o}), 64'(0));
        chk("rst_rd0", 64'(m0_r_data_o), 64'(0));
        chk("rst_rd1", 64'(m1_r_data_o), 64'(0));

        // Ack with no transaction pending must be ignored.
        stray = 1'b1;
        tick();
        tick();
        stray = 1'b0;
        fll_ack_i = 1'b0;
        chk("stray_ack", 64'({busy_o, fll_req_o, m0_ack_o, m1_ack_o}),
            64'(0));

        // m0 write, FLL acks 3 cycles after its request rises.
        m0_req_i = 1'b1;
        m0_wrn_i = 1'b0;
        m0_add_i = 2'd2;
        m0_data_i = 32'h0000_1234;
        run_txn(4, 32'hDEAD_BEEF, 1'b0, 1'b0);
        m0_req_i = 1'b0;

        // m1 read.
        m1_req_i = 1'b1;
        m1_wrn_i = 1'b1;
        m1_add_i = 2'd1;
        m1_data_i = $urandom;
        run_txn(2, 32'hCAFE_0001, 1'b0, 1'b0);
        m1_req_i = 1'b0;

        // Contention held across four transactions.
        m0_req_i = 1'b1;
        m0_wrn_i = 1'b0;
        m0_add_i = 2'd3;
        m0_data_i = 32'hA0A0_0000;
        m1_req_i = 1'b1;
        m1_wrn_i = 1'b1;
        m1_add_i = 2'd0;
        m1_data_i = 32'h0B0B_0000;
        for (int i = 0; i < 4; i++) begin
            run_txn($urandom_range(2, 6), $urandom, 1'b0, 1'b0);
        end
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;

        // Timeout, late ack on the last window cycle, ack in ISSUE.
        m0_req_i = 1'b1;
        m0_wrn_i = 1'b1;
        run_txn(5, 32'h1111_2222, 1'b1, 1'b0);
        m0_req_i = 1'b0;
        m1_req_i = 1'b1;
        run_txn(3, 32'h3333_4444, 1'b0, 1'b0);
        m1_req_i = 1'b0;
        m0_req_i = 1'b1;
        run_txn(TMO + 1, 32'h5555_6666, 1'b0, 1'b0);
        run_txn(TMO + 2, 32'h7777_8888, 1'b0, 1'b0);
        run_txn(1, 32'h9999_AAAA, 1'b0, 1'b0);

        // Requester withdraws right after being granted.
        run_txn(3, 32'hBBBB_CCCC, 1'b0, 1'b1);
        m0_req_i = 1'b0;

        // Reset in WAIT_ACK restores idle state and m0 priority.
        m0_req_i = 1'b1;
        m0_wrn_i = 1'b0;
        run_txn(2, 32'h0, 1'b0, 1'b0);
        m0_req_i = 1'b0;
        m1_req_i = 1'b1;
        fll_mute = 1'b1;
        tick();
        tick();
        chk("pre_rst", 64'({busy_o, fll_req_o}), 64'(2'b11));
        rst_i = 1'b1;
        tick();
        chk("rst_mid", 64'({fll_req_o, busy_o, m0_ack_o, m1_ack_o}),
            64'(0));
        chk("rst_mid_rd", 64'({m0_r_data_o, m1_r_data_o}), 64'(0));
        rst_i = 1'b0;
        prio = 0;
        mdl_rd[0] = '0;
        mdl_rd[1] = '0;
        m0_req_i = 1'b1;
        run_txn(2, 32'h1357_9BDF, 1'b0, 1'b0);
        m0_req_i = 1'b0;
        run_txn(3, 32'h2468_ACE0, 1'b0, 1'b0);
        m1_req_i = 1'b0;

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(1, 3);
            m0_req_i = r[0];
            m1_req_i = r[1];
            m0_wrn_i = 1'($urandom);
            m1_wrn_i = 1'($urandom);
            m0_add_i = 2'($urandom);
            m1_add_i = 2'($urandom);
            m0_data_i = $urandom;
            m1_data_i = $urandom;
            run_txn($urandom_range(1, TMO + 4), $urandom,
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) begin
                m0_req_i = 1'b0;
                m1_req_i = 1'b0;
                tick();
                chk("gap_idle", 64'({busy_o, fll_req_o}), 64'(0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fll_cfg_arbiter.md
FLL_CFG_ARBITER -- requirements
Module: fll_cfg_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256; maximum cycles to wait for fll_ack_i before aborting a transaction.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic on the rising edge.
REQ-003 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports mN_req_i (input, 1), mN_wrn_i (input, 1, 1=read, 0=write), mN_add_i (input, 2) and mN_data_i (input, 32), for N=0,1; the requester command.
REQ-005 SHALL have ports mN_ack_o (output, 1, single-cycle completion pulse), mN_r_data_o (output, 32, read data) and mN_err_o (output, 1, timeout flag, valid with ack), for N=0,1.
REQ-006 SHALL have ports fll_req_o (output, 1), fll_wrn_o (output, 1), fll_add_o (output, 2) and fll_data_o (output, 32), driving the FLL configuration port.
REQ-007 SHALL have ports fll_ack_i (input, 1) and fll_r_data_i (input, 32), the FLL response.
REQ-008 SHALL have port busy_o, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK and RESP.
REQ-010 IDLE: when any mN_req_i is high, SHALL select one requester, latch its wrn/add/data into command registers and go to ISSUE.
REQ-011 Arbitration SHALL be round-robin between the two requesters; after requester i completes (ack or timeout), requester 1-i SHALL have priority; a sole requester SHALL always win.
REQ-012 ISSUE SHALL assert fll_req_o with the latched command and go to WAIT_ACK; fll_req_o is high on the cycle after the request is seen in IDLE.
REQ-013 WAIT_ACK SHALL hold fll_req_o and the command stable until fll_ack_i is sampled high, then deassert fll_req_o, register fll_r_data_i (reads only; writes return 0) and go to RESP.
REQ-014 RESP SHALL pulse the granted mN_ack_o for exactly one cycle with mN_r_data_o valid, then return to IDLE; the minimum transaction is 4 cycles from request to ack.
REQ-015 The timeout counter SHALL be cleared in ISSUE and increment each WAIT_ACK cycle; on reaching TIMEOUT_CYCLES-1 without fll_ack_i, SHALL drop fll_req_o and go to RESP with r_data=0 and mN_err_o=1.
REQ-016 fll_ack_i arriving on the same cycle as the timeout SHALL count as success (err_o=0).
REQ-017 fll_ack_i seen outside WAIT_ACK SHALL be ignored.
REQ-018 A transaction SHALL be committed once latched: the requester deasserting req mid-transaction does not abort it, and the ack pulse is still issued.
REQ-019 A non-granted requester's ack/err/r_data SHALL stay 0; mN_r_data_o SHALL hold its value between acks.
REQ-020 A requester holding req high after its ack SHALL be treated as a new request, subject to round-robin.

Reset
REQ-021 On rst_i, the FSM SHALL go to IDLE next cycle, including mid-transaction with no ack issued.
REQ-022 Reset values SHALL be: fll_req_o=0, fll_wrn_o=0, fll_add_o=0, fll_data_o=0, all mN_ack_o/mN_err_o=0, mN_r_data_o=0, busy_o=0, round-robin priority=requester 0, timeout counter=0.

Structure
REQ-023 Package fll_cfg_pkg SHALL hold the FSM state enum, the requester index type, FLL_ADDR_W=2, FLL_DATA_W=32 and the default TIMEOUT_CYCLES.
REQ-024 The two-way round-robin selector SHALL be the single sub-module rr_arb2 (combinational grant plus a registered priority bit updated on completion).
REQ-025 The block SHALL sit between the SoC/debug requesters and the fll_* port of the clock/reset generator.

Verification
REQ-026 m0 write add=2, data=32'h0000_1234; FLL acks 3 cycles after fll_req_o -> fll_add_o=2, fll_data_o=32'h1234, fll_wrn_o=0; m0_ack_o one pulse; m0_err_o=0.
REQ-027 m1 read add=1; FLL acks with r_data=32'hCAFE_0001 -> m1_ack_o pulse with m1_r_data_o=32'hCAFE_0001; m0 outputs stay 0.
REQ-028 m0 and m1 request on the same cycle after reset, both held high -> order m0, m1, m0, m1 across four transactions.
REQ-029 TIMEOUT_CYCLES=16, FLL never acks -> fll_req_o drops after 16 WAIT_ACK cycles; ack pulse with err=1, r_data=0; the next request proceeds normally.
REQ-030 rst_i pulsed in WAIT_ACK -> next cycle fll_req_o=0, busy_o=0, no ack; a subsequent m1 request is granted with m0 priority restored.
REQ-031 m0 drops req the cycle after IDLE grants it -> the FLL transaction still completes and m0_ack_o pulses once.
